// File: rtl/segment_register_file_if.sv
// Bus bundle for segment_register_file: load/done handshake, descriptor fetch, read port.
interface segment_register_file_if #(
  parameter int unsigned SEGMENT_COUNT  = 6,
  parameter int unsigned SELECTOR_WIDTH = 16,
  parameter int unsigned BASE_WIDTH     = 32,
  parameter int unsigned LIMIT_WIDTH    = 32,
  parameter int unsigned ATTR_WIDTH     = 8
);
  localparam int unsigned IW = (SEGMENT_COUNT > 1) ? $clog2(SEGMENT_COUNT) : 1;

  logic                                    protected_mode;
  logic                                    load_valid;
  logic                                    load_ready;
  logic [IW-1:0]                           load_index;
  logic [SELECTOR_WIDTH-1:0]               load_selector;

  logic                                    desc_req_valid;
  logic [SELECTOR_WIDTH-1:0]               desc_req_selector;
  logic                                    desc_resp_valid;
  logic [BASE_WIDTH-1:0]                   desc_resp_base;
  logic [LIMIT_WIDTH-1:0]                  desc_resp_limit;
  logic [ATTR_WIDTH-1:0]                   desc_resp_attr;
  logic                                    desc_resp_fault;

  logic                                    done_valid;
  logic                                    done_fault;

  logic [IW-1:0]                           read_index;
  logic [SELECTOR_WIDTH-1:0]               read_selector;
  logic [BASE_WIDTH-1:0]                   read_base;
  logic [LIMIT_WIDTH-1:0]                  read_limit;
  logic [ATTR_WIDTH-1:0]                   read_attr;
  logic [SEGMENT_COUNT*SELECTOR_WIDTH-1:0] selector_flat;

  modport master (
    output protected_mode, load_valid, load_index, load_selector,
    output desc_resp_valid, desc_resp_base, desc_resp_limit, desc_resp_attr, desc_resp_fault,
    output read_index,
    input  load_ready, desc_req_valid, desc_req_selector, done_valid, done_fault,
    input  read_selector, read_base, read_limit, read_attr, selector_flat
  );

  modport slave (
    input  protected_mode, load_valid, load_index, load_selector,
    input  desc_resp_valid, desc_resp_base, desc_resp_limit, desc_resp_attr, desc_resp_fault,
    input  read_index,
    output load_ready, desc_req_valid, desc_req_selector, done_valid, done_fault,
    output read_selector, read_base, read_limit, read_attr, selector_flat
  );
endinterface

// File: rtl/segment_register_file.sv
// Segment register file with hidden descriptor cache; real-mode loads are local, protected-mode
// loads fetch a descriptor. Optional write-to-read forwarding: SEGMENT_REGISTER_FILE_BYPASS_EN.
module segment_register_file #(
  parameter int unsigned SEGMENT_COUNT  = 6,
  parameter int unsigned SELECTOR_WIDTH = 16,
  parameter int unsigned BASE_WIDTH     = 32,
  parameter int unsigned LIMIT_WIDTH    = 32,
  parameter int unsigned ATTR_WIDTH     = 8
) (
  input logic                   clock,
  input logic                   reset,
  segment_register_file_if.slave bus
);
  localparam int unsigned IW = (SEGMENT_COUNT > 1) ? $clog2(SEGMENT_COUNT) : 1;
  localparam logic [LIMIT_WIDTH-1:0] RESET_LIMIT = LIMIT_WIDTH'(32'h0000_FFFF);
  localparam logic [ATTR_WIDTH-1:0]  RESET_ATTR  = ATTR_WIDTH'(8'h93);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [SELECTOR_WIDTH-1:0] lsel_q, lsel_d;
  logic                      fault_q, fault_d;

  logic [SELECTOR_WIDTH-1:0] sel_q   [SEGMENT_COUNT];
  logic [BASE_WIDTH-1:0]     base_q  [SEGMENT_COUNT];
  logic [LIMIT_WIDTH-1:0]    limit_q [SEGMENT_COUNT];
  logic [ATTR_WIDTH-1:0]     attr_q  [SEGMENT_COUNT];

  logic                      wr_en;
  logic [IW-1:0]             wr_idx;
  logic [SELECTOR_WIDTH-1:0] wr_sel;
  logic [BASE_WIDTH-1:0]     wr_base;
  logic [LIMIT_WIDTH-1:0]    wr_limit;
  logic [ATTR_WIDTH-1:0]     wr_attr;

  logic load_in_range;
  logic load_null;
  logic load_is_cs_ss;

  assign load_in_range = (32'(bus.load_index) < SEGMENT_COUNT);
  assign load_null     = (bus.load_selector[SELECTOR_WIDTH-1:2] == '0);
  assign load_is_cs_ss = (32'(bus.load_index) < 32'd2);

  // Next-state logic; the cache write port is driven in the commit cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lsel_d   = lsel_q;
    fault_d  = fault_q;
    wr_en    = 1'b0;
    wr_idx   = idx_q;
    wr_sel   = lsel_q;
    wr_base  = '0;
    wr_limit = '0;
    wr_attr  = '0;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          idx_d   = bus.load_index;
          lsel_d  = bus.load_selector;
          fault_d = 1'b0;
          wr_idx  = bus.load_index;
          wr_sel  = bus.load_selector;
          state_d = DONE;
          if (!load_in_range) begin
            fault_d = 1'b1;
          end else if (!bus.protected_mode) begin
            wr_en    = 1'b1;
            wr_base  = BASE_WIDTH'({bus.load_selector, 4'h0});
            wr_limit = RESET_LIMIT;
            wr_attr  = RESET_ATTR;
          end else if (load_null) begin
            if (load_is_cs_ss) begin
              fault_d = 1'b1;
            end else begin
              // Null data segment: keep base/limit, mark the entry not-present.
              wr_en      = 1'b1;
              wr_base    = base_q[bus.load_index];
              wr_limit   = limit_q[bus.load_index];
              wr_attr    = attr_q[bus.load_index];
              wr_attr[7] = 1'b0;
            end
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (bus.desc_resp_valid) begin
          state_d = DONE;
          if (bus.desc_resp_fault) begin
            fault_d = 1'b1;
          end else begin
            wr_en    = 1'b1;
            wr_base  = bus.desc_resp_base;
            wr_limit = bus.desc_resp_limit;
            wr_attr  = bus.desc_resp_attr;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lsel_q  <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < int'(SEGMENT_COUNT); i++) begin
        sel_q[i]   <= '0;
        base_q[i]  <= '0;
        limit_q[i] <= RESET_LIMIT;
        attr_q[i]  <= RESET_ATTR;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lsel_q  <= lsel_d;
      fault_q <= fault_d;
      if (wr_en) begin
        sel_q[wr_idx]   <= wr_sel;
        base_q[wr_idx]  <= wr_base;
        limit_q[wr_idx] <= wr_limit;
        attr_q[wr_idx]  <= wr_attr;
      end
    end
  end

  assign bus.load_ready        = (state_q == IDLE);
  assign bus.desc_req_valid    = (state_q == FETCH);
  assign bus.desc_req_selector = lsel_q;
  assign bus.done_valid        = (state_q == DONE);
  assign bus.done_fault        = (state_q == DONE) && fault_q;

  // Combinational read port; out-of-range index reads as zero.
  always_comb begin
    bus.read_selector = '0;
    bus.read_base     = '0;
    bus.read_limit    = '0;
    bus.read_attr     = '0;
    if (32'(bus.read_index) < SEGMENT_COUNT) begin
      bus.read_selector = sel_q[bus.read_index];
      bus.read_base     = base_q[bus.read_index];
      bus.read_limit    = limit_q[bus.read_index];
      bus.read_attr     = attr_q[bus.read_index];
    end
`ifdef SEGMENT_REGISTER_FILE_BYPASS_EN
    if (wr_en && (bus.read_index == wr_idx)) begin
      bus.read_selector = wr_sel;
      bus.read_base     = wr_base;
      bus.read_limit    = wr_limit;
      bus.read_attr     = wr_attr;
    end
`else
`endif
  end

  for (genvar g = 0; g < int'(SEGMENT_COUNT); g++) begin : g_flat
    assign bus.selector_flat[g*SELECTOR_WIDTH +: SELECTOR_WIDTH] = sel_q[g];
  end
endmodule

// File: tb/tb_segment_register_file.sv
// Randomized self-checking bench for segment_register_file against an array-based reference model.
module tb_segment_register_file;
  localparam int unsigned SC = 6;
  localparam int unsigned SW = 16;
  localparam int unsigned BW = 32;
  localparam int unsigned LW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = $clog2(SC);

`ifdef SEGMENT_REGISTER_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  segment_register_file_if #(.SEGMENT_COUNT(SC), .SELECTOR_WIDTH(SW), .BASE_WIDTH(BW),
                             .LIMIT_WIDTH(LW), .ATTR_WIDTH(AW)) bus ();

  segment_register_file #(.SEGMENT_COUNT(SC), .SELECTOR_WIDTH(SW), .BASE_WIDTH(BW),
                          .LIMIT_WIDTH(LW), .ATTR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [SW-1:0] m_sel   [SC];
  logic [BW-1:0] m_base  [SC];
  logic [LW-1:0] m_limit [SC];
  logic [AW-1:0] m_attr  [SC];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(SC); i++) begin
      m_sel[i]   = '0;
      m_base[i]  = '0;
      m_limit[i] = 32'h0000_FFFF;
      m_attr[i]  = 8'h93;
    end
  endtask

  task automatic check_port(input string tag, input logic [SW-1:0] es, input logic [BW-1:0] eb,
                            input logic [LW-1:0] el, input logic [AW-1:0] ea);
    check({tag, ".sel"},   128'(bus.read_selector), 128'(es));
    check({tag, ".base"},  128'(bus.read_base),     128'(eb));
    check({tag, ".limit"}, 128'(bus.read_limit),    128'(el));
    check({tag, ".attr"},  128'(bus.read_attr),     128'(ea));
  endtask

  // Sweeps every read index (including out-of-range) while idle, then realigns to negedge.
  task automatic check_reads();
    logic [SC*SW-1:0] f;
    for (int i = 0; i < (1 << IW); i++) begin
      bus.read_index = IW'(i);
      #1;
      if (i < int'(SC)) check_port("read", m_sel[i], m_base[i], m_limit[i], m_attr[i]);
      else              check_port("read_oor", '0, '0, '0, '0);
    end
    for (int i = 0; i < int'(SC); i++) f[i*SW +: SW] = m_sel[i];
    check("selector_flat", 128'(bus.selector_flat), 128'(f));
    @(negedge clock);
  endtask

  // One complete load transaction, starting and ending aligned to a falling edge.
  task automatic do_load(input bit pm, input logic [IW-1:0] idx, input logic [SW-1:0] sel,
                         input int delay, input bit rfault, input logic [BW-1:0] rb,
                         input logic [LW-1:0] rl, input logic [AW-1:0] ra);
    bit in_range, nul, fetch, commit, efault;
    logic [SW-1:0] os, ns;
    logic [BW-1:0] ob, nb;
    logic [LW-1:0] ol, nl;
    logic [AW-1:0] oa, na;
    in_range = (int'(idx) < int'(SC));
    nul      = (sel[SW-1:2] == '0);
    fetch    = in_range && pm && !nul;
    commit   = in_range && (!pm || (nul && int'(idx) >= 2));
    efault   = !in_range || (pm && nul && int'(idx) < 2);
    os = '0; ob = '0; ol = '0; oa = '0;
    if (in_range) begin
      os = m_sel[idx]; ob = m_base[idx]; ol = m_limit[idx]; oa = m_attr[idx];
    end
    ns = sel;
    if (!pm) begin
      nb = BW'(sel) * 16; nl = 32'h0000_FFFF; na = 8'h93;
    end else begin
      nb = ob; nl = ol; na = oa & 8'h7F;
    end

    bus.load_valid     = 1'b1;
    bus.protected_mode = pm;
    bus.load_index     = idx;
    bus.load_selector  = sel;
    bus.read_index     = idx;
    #1;
    check("accept_ready", 128'(bus.load_ready), 128'(1));
    if (commit && BYP) check_port("commit_T", ns, nb, nl, na);
    else               check_port("commit_T", os, ob, ol, oa);
    @(negedge clock);
    bus.load_valid     = 1'b0;
    bus.protected_mode = 1'($urandom);
    bus.load_selector  = SW'($urandom);

    if (fetch) begin
      for (int d = 0; d <= delay; d++) begin
        #1;
        check("req_valid", 128'(bus.desc_req_valid),    128'(1));
        check("req_sel",   128'(bus.desc_req_selector), 128'(sel));
        check("done_early",128'(bus.done_valid),        128'(0));
        if (d == delay) begin
          bus.desc_resp_valid = 1'b1;
          bus.desc_resp_fault = rfault;
          bus.desc_resp_base  = rb;
          bus.desc_resp_limit = rl;
          bus.desc_resp_attr  = ra;
          #1;
          if (!rfault && BYP) check_port("commit_R", sel, rb, rl, ra);
          else                check_port("commit_R", os, ob, ol, oa);
        end
        @(negedge clock);
      end
      bus.desc_resp_valid = 1'b0;
      commit = !rfault;
      efault = rfault;
      nb = rb; nl = rl; na = ra;
    end

    #1;
    check("done_valid", 128'(bus.done_valid),     128'(1));
    check("done_fault", 128'(bus.done_fault),     128'(efault));
    check("done_req",   128'(bus.desc_req_valid), 128'(0));
    check("done_ready", 128'(bus.load_ready),     128'(0));
    if (commit) begin
      m_sel[idx] = ns; m_base[idx] = nb; m_limit[idx] = nl; m_attr[idx] = na;
    end
    @(negedge clock);
    #1;
    check("idle_ready", 128'(bus.load_ready), 128'(1));
    check("idle_done",  128'(bus.done_valid), 128'(0));
    check_reads();
  endtask

  task automatic reset_mid_fetch();
    bus.load_valid     = 1'b1;
    bus.protected_mode = 1'b1;
    bus.load_index     = IW'(5);
    bus.load_selector  = 16'h0028;
    @(negedge clock);
    bus.load_valid = 1'b0;
    #1;
    check("rst_fetch_req", 128'(bus.desc_req_valid), 128'(1));
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("rst_req_drop", 128'(bus.desc_req_valid), 128'(0));
    check("rst_no_done",  128'(bus.done_valid),     128'(0));
    reset = 1'b0;
    bus.desc_resp_valid = 1'b1;
    bus.desc_resp_fault = 1'b0;
    bus.desc_resp_base  = 32'hDEAD_0000;
    bus.desc_resp_limit = 32'h0000_0FFF;
    bus.desc_resp_attr  = 8'h9A;
    @(negedge clock);
    #1;
    bus.desc_resp_valid = 1'b0;
    check("late_no_done", 128'(bus.done_valid), 128'(0));
    check("late_ready",   128'(bus.load_ready), 128'(1));
    model_reset();
    @(negedge clock);
    check_reads();
  endtask

  initial begin
    reset               = 1'b1;
    bus.protected_mode  = 1'b0;
    bus.load_valid      = 1'b1;
    bus.load_index      = IW'(2);
    bus.load_selector   = 16'hFFFF;
    bus.desc_resp_valid = 1'b0;
    bus.desc_resp_base  = '0;
    bus.desc_resp_limit = '0;
    bus.desc_resp_attr  = '0;
    bus.desc_resp_fault = 1'b0;
    bus.read_index      = '0;
    model_reset();
    repeat (3) @(negedge clock);
    bus.load_valid = 1'b0;
    reset          = 1'b0;
    #1;
    check("rst_ready",     128'(bus.load_ready),     128'(1));
    check("rst_req_valid", 128'(bus.desc_req_valid), 128'(0));
    check("rst_done",      128'(bus.done_valid),     128'(0));
    check("rst_fault",     128'(bus.done_fault),     128'(0));
    @(negedge clock);
    check_reads();

    do_load(1'b0, IW'(2), 16'h1234, 0, 1'b0, '0, '0, '0);
    do_load(1'b1, IW'(3), 16'h0010, 3, 1'b0, 32'h0040_0000, 32'h000F_FFFF, 8'h92);
    do_load(1'b1, IW'(1), 16'h0003, 0, 1'b0, '0, '0, '0);
    do_load(1'b1, IW'(4), 16'h0003, 0, 1'b0, '0, '0, '0);
    do_load(1'b1, IW'(2), 16'h0018, 1, 1'b1, 32'h1111_1111, 32'h2222, 8'h93);
    do_load(1'b0, IW'(6), 16'hABCD, 0, 1'b0, '0, '0, '0);
    do_load(1'b1, IW'(7), 16'h0040, 0, 1'b0, '0, '0, '0);
    do_load(1'b1, IW'(0), 16'h0008, 0, 1'b0, 32'h0001_0000, 32'h0000_7FFF, 8'h9B);
    do_load(1'b0, IW'(2), 16'hFFFF, 0, 1'b0, '0, '0, '0);
    reset_mid_fetch();

    for (int n = 0; n < 150; n++) begin
      logic [SW-1:0] s;
      s = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 3)) : SW'($urandom);
      do_load(1'($urandom), IW'($urandom_range(0, (1 << IW) - 1)), s,
              int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
              BW'($urandom), LW'($urandom), AW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
